// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC / instruction-fetch block: reset PC, step size
// and the fetch controller state encoding.
package pc_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DROP = 2'd2,
        FETCH_WAIT = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_fsm.sv
// Fetch controller state machine: tracks whether a memory request is
// outstanding, being discarded (DROP) or parked behind a full output slot.
module pc_fetch_fsm
    import pc_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_pcload,
    input  logic         i_ack,
    input  logic         i_stall,
    output fetch_state_e o_state,
    output logic         o_req
);

    fetch_state_e r_state;
    fetch_state_e w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FETCH_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH_IDLE: w_next = FETCH_REQ;
            FETCH_REQ: begin
                // An ack that cannot be delivered (stall) parks the fetcher;
                // the pc is only advanced when the word is actually captured.
                if (i_ack) begin
                    if (!i_pcload && i_stall) w_next = FETCH_WAIT;
                end else if (i_pcload) begin
                    w_next = FETCH_DROP;
                end
            end
            FETCH_DROP: if (i_ack) w_next = FETCH_REQ;
            FETCH_WAIT: if (i_pcload || !i_stall) w_next = FETCH_REQ;
            default:    w_next = FETCH_IDLE;
        endcase
    end

    always_comb begin
        o_state = r_state;
        o_req   = (r_state == FETCH_REQ) || (r_state == FETCH_DROP);
    end

endmodule

// File: rtl/pc_fetch.sv
// Program counter plus instruction fetch: issues req/ack fetches at the PC,
// applies redirects, and holds one fetched instruction for decode.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcload,
    input  logic [31:0] pcaddr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    fetch_state_e w_state;
    logic         w_req;
    logic [31:0]  w_target;
    logic         w_slot_free;
    logic         w_capture;
    logic         w_unused;

    logic [31:0]  r_pc;
    logic [31:0]  r_redir;
    logic         r_valid;
    logic [31:0]  r_instr;
    logic [31:0]  r_ipc;

    pc_fetch_fsm u_fsm (
        .clk      (clk),
        .rst      (rst),
        .i_pcload (pcload),
        .i_ack    (imem_ack),
        .i_stall  (stall),
        .o_state  (w_state),
        .o_req    (w_req)
    );

    assign w_target    = align_word(pcaddr);
    assign w_unused    = ^pcaddr[1:0];
    assign w_slot_free = !r_valid || !stall;
    assign w_capture   = (w_state == FETCH_REQ) && imem_ack && !pcload && w_slot_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_redir <= RESET_PC;
        end else begin
            case (w_state)
                FETCH_IDLE: if (pcload) r_pc <= w_target;
                FETCH_REQ: begin
                    if (imem_ack) begin
                        if (pcload)           r_pc <= w_target;
                        else if (w_slot_free) r_pc <= r_pc + PC_STEP;
                    end else if (pcload) begin
                        r_redir <= w_target;
                    end
                end
                FETCH_DROP: begin
                    if (pcload) r_redir <= w_target;
                    if (imem_ack) r_pc <= pcload ? w_target : r_redir;
                end
                FETCH_WAIT: if (pcload) r_pc <= w_target;
                default:    r_pc <= RESET_PC;
            endcase
        end
    end

    // Output slot: a redirect flushes it, otherwise it fills on capture and
    // empties once decode accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_ipc   <= 32'd0;
        end else if (pcload) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_instr <= imem_rdata;
            r_ipc   <= r_pc;
        end else if (r_valid && !stall) begin
            r_valid <= 1'b0;
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign if_valid  = r_valid;
    assign if_instr  = r_instr;
    assign if_pc     = r_ipc;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus random traffic,
// compared every cycle against a behavioural fetch model.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcload;
    logic [31:0] pcaddr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int checks = 0;
    int errors = 0;

    // Behavioural model: started / fetch outstanding / redirect pending.
    logic        m_started, m_busy, m_pend;
    logic [31:0] m_pc, m_tgt;
    logic        m_v;
    logic [31:0] m_instr, m_ipc;

    pc_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pcload     (pcload),
        .pcaddr     (pcaddr),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_busy = 0; m_pend = 0;
        m_pc = 32'h0; m_tgt = 32'h0;
        m_v = 0; m_instr = 32'h0; m_ipc = 32'h0;
    endtask

    task automatic chk_all();
        chk("req",   {31'd0, imem_req}, {31'd0, m_busy});
        chk("addr",  imem_addr, m_pc);
        chk("valid", {31'd0, if_valid}, {31'd0, m_v});
        chk("instr", if_instr, m_instr);
        chk("ifpc",  if_pc, m_ipc);
    endtask

    // One cycle: drive at negedge, advance model, check #1 after posedge.
    task automatic step(input logic pl, input logic [31:0] a, input logic st, input logic ack_en);
        logic        ack, cap;
        logic [31:0] tgt;
        ack = ack_en && m_busy;
        tgt = {a[31:2], 2'b00};
        pcload = pl; pcaddr = a; stall = st;
        imem_ack = ack; imem_rdata = m_pc ^ 32'hA5A5A5A5;
        cap = 0;
        if (!m_started) begin
            if (pl) m_pc = tgt;
            m_started = 1; m_busy = 1;
        end else if (m_busy) begin
            if (ack) begin
                if (m_pend) begin
                    m_pc = pl ? tgt : m_tgt; m_pend = 0;
                end else if (pl) begin
                    m_pc = tgt;
                end else if (!m_v || !st) begin
                    cap = 1; m_instr = m_pc ^ 32'hA5A5A5A5; m_ipc = m_pc;
                    m_pc = m_pc + 32'd4; m_busy = !st;
                end else begin
                    m_busy = 0;
                end
            end else if (pl) begin
                m_pend = 1; m_tgt = tgt;
            end
        end else begin
            if (pl) begin m_pc = tgt; m_busy = 1; end
            else if (!st) m_busy = 1;
        end
        if (pl) m_v = 0;
        else if (cap) m_v = 1;
        else if (m_v && !st) m_v = 0;
        @(posedge clk);
        #1;
        chk_all();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; pcload = 0; pcaddr = 0; stall = 0; imem_ack = 0; imem_rdata = 0;
        model_reset();
        #1;
        chk_all();
        @(negedge clk); @(negedge clk);
        rst = 0;

        step(0, 0, 0, 0);
        chk("start_addr0", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        chk("seq_ifpc0", if_pc, 32'h0);
        chk("seq_addr4", imem_addr, 32'h4);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("seq_ifpc8", if_pc, 32'h8);
        chk("seq_addrC", imem_addr, 32'hC);

        step(0, 0, 1, 1);
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        step(0, 0, 1, 1);
        chk("stall_hold", if_pc, 32'h8);
        step(0, 0, 0, 0);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'hC);

        step(1, 32'h12345678, 0, 0);
        chk("drop_old", imem_addr, 32'hC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("drop_new", imem_addr, 32'h12345678);
        chk("drop_nvalid", {31'd0, if_valid}, 32'd0);

        step(1, 32'h87654321, 0, 1);
        chk("ackload", imem_addr, 32'h87654320);

        step(1, 32'hFFFFFFFC, 0, 1);
        step(0, 0, 0, 1);
        chk("wrap_hi", if_pc, 32'hFFFFFFFC);
        step(0, 0, 0, 1);
        chk("wrap_lo", if_pc, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        step(1, 32'h100, 0, 0);
        step(0, 0, 0, 1);
        chk("prerst_req", {31'd0, imem_req}, 32'd1);
        rst = 1;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        chk_all();
        rst = 0;
        step(0, 0, 0, 1);
        chk("rst_addr", imem_addr, 32'h0);
        step(0, 0, 0, 1);
        chk("rst_ifpc", if_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
